// File: rtl/ysyx_l1i_bus_bridge.sv
// ysyx_l1i_bus_bridge: L1I line-fill responder issuing one AXI4 INCR burst per request
module ysyx_l1i_bus_bridge #(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            arvalid,
  input  logic [XLEN-1:0] araddr,
  output logic            bus_ready,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            rlast,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [XLEN-1:0] m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [XLEN-1:0] m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  output logic            bus_err
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [XLEN-1:0] OFF_MASK = XLEN'(LINE_WORDS * XLEN / 8 - 1);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic beat, last_beat;
  assign beat      = m_rvalid && m_rready;
  assign last_beat = cnt == LAST;
  assign bus_ready = state == IDLE;
  assign m_arvalid = state == AR;
  assign m_rready  = state == R;
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = 3'($clog2(XLEN / 8));
  assign m_arburst = 2'b01;
  // state register; reset abandons any burst in flight
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // request accept, AR handshake, and final-beat return to idle
  always_comb begin
    state_nxt = state;
    state_nxt = (bus_ready && arvalid)  ? AR   :
                (m_arvalid && m_arready) ? R    :
                (beat && last_beat)      ? IDLE : state;
  end
  // latched burst address, beat counter and registered L1I-side return path
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt      <= '0;
      m_araddr <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      rvalid  <= beat;
      rlast   <= beat && last_beat;
      bus_err <= beat && (m_rresp != 2'b00 || m_rlast != last_beat);
      if (bus_ready && arvalid) m_araddr <= araddr & ~OFF_MASK;
      if (m_arvalid && m_arready) cnt <= '0;
      else if (beat) cnt <= cnt + 1'b1;
      if (beat) rdata <= m_rdata;
    end
endmodule

// File: tb/tb_ysyx_l1i_bus_bridge.sv
// tb_ysyx_l1i_bus_bridge: directed fills checked against a transaction-level model
module tb_ysyx_l1i_bus_bridge;
  localparam int LW = 4;
  localparam int LB = LW * 4;
  logic clk = 0, rst_n = 0;
  logic arvalid = 0, m_arready = 0, m_rvalid = 0, m_rlast = 0;
  logic [31:0] araddr = 0, m_rdata = 0;
  logic [1:0] m_rresp = 0;
  logic bus_ready, rvalid, rlast, m_arvalid, m_rready, bus_err;
  logic [31:0] rdata, m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst;
  int tests = 0, fails = 0, cyc = 0;

  ysyx_l1i_bus_bridge #(.XLEN(32), .LINE_WORDS(LW)) dut (
    .clock(clk), .reset(rst_n), .arvalid(arvalid), .araddr(araddr), .bus_ready(bus_ready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transaction model: phase 0 waiting for request, 1 address issued, 2 collecting beats
  int phase = 0, beat_i = 0;
  logic [31:0] exp_addr = 0, exp_rdata = 0;
  logic exp_rv = 0, exp_last = 0, exp_err = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= 0; beat_i <= 0; exp_addr <= 0; exp_rdata <= 0;
      exp_rv <= 0; exp_last <= 0; exp_err <= 0;
    end else begin
      exp_rv   <= phase == 2 && m_rvalid;
      exp_last <= phase == 2 && m_rvalid && beat_i == LW - 1;
      exp_err  <= phase == 2 && m_rvalid && (m_rresp != 0 || m_rlast != (beat_i == LW - 1));
      if (phase == 2 && m_rvalid) exp_rdata <= m_rdata;
      if (phase == 0 && arvalid) begin
        phase <= 1; exp_addr <= araddr - (araddr % LB);
      end else if (phase == 1 && m_arready) begin
        phase <= 2; beat_i <= 0;
      end else if (phase == 2 && m_rvalid) begin
        beat_i <= beat_i + 1;
        if (beat_i == LW - 1) phase <= 0;
      end
    end

  logic checking = 0;
  always @(negedge clk)
    if (checking) begin
      check("bus_ready", bus_ready, phase == 0);
      check("m_arvalid", m_arvalid, phase == 1);
      check("m_rready", m_rready, phase == 2);
      check("m_araddr", m_araddr, exp_addr);
      check("rvalid", rvalid, exp_rv);
      check("rlast", rlast, exp_last);
      check("bus_err", bus_err, exp_err);
      check("rdata", rdata, exp_rdata);
      check("m_arlen", m_arlen, 3);
      check("m_arsize", m_arsize, 2);
      check("m_arburst", m_arburst, 1);
    end

  typedef struct {logic [31:0] d; logic l; logic e; int c;} pulse_t;
  pulse_t pq[$];
  int arq[$];
  int arv_cnt = 0;
  logic prev_arv = 0;
  logic [31:0] ar_seen = 0;
  always @(negedge clk) begin
    if (rvalid) pq.push_back('{rdata, rlast, bus_err, cyc});
    if (m_arvalid && !prev_arv) arq.push_back(cyc);
    if (m_arvalid) begin arv_cnt <= arv_cnt + 1; ar_seen <= m_araddr; end
    prev_arv <= m_arvalid;
  end

  // memory-side driver: pat bit s says whether slot s carries a beat
  task automatic do_fill(input logic [31:0] addr, input int ar_stall, input logic [15:0] pat,
                         input int resp_beat, input int bad_last, input logic [31:0] base,
                         input logic hold, input int stop_after);
    int b, s, k;
    arvalid = 1; araddr = addr; k = 0;
    while (!bus_ready && k < 50) begin @(negedge clk); k++; end
    if (!bus_ready) begin
      check("accept_timeout", bus_ready, 1); arvalid = 0; return;
    end
    @(negedge clk); arvalid = hold;
    for (int i = 0; i < ar_stall; i++) begin m_arready = 0; @(negedge clk); end
    m_arready = 1; @(negedge clk); m_arready = 0;
    b = 0; s = 0;
    while (b < stop_after && s < 16) begin
      m_rvalid = pat[s]; m_rdata = base + b;
      m_rresp = (b == resp_beat) ? 2'd2 : 2'd0;
      m_rlast = (b == LW - 1) ^ (b == bad_last);
      if (pat[s]) b++;
      s++;
      @(negedge clk);
    end
    m_rvalid = 0; m_rresp = 0; m_rlast = 0;
  endtask

  int a0;
  initial begin
    repeat (2) @(negedge clk);
    checking = 1;
    check("rst_bus_ready", bus_ready, 1);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_m_araddr", m_araddr, 0);
    rst_n = 1;
    m_rvalid = 1; repeat (3) @(negedge clk); m_rvalid = 0;
    check("ignore_rvalid", rvalid, 0);
    check("ignore_bus_ready", bus_ready, 1);
    // basic fill
    pq.delete(); a0 = arv_cnt;
    do_fill(32'h8000_0014, 0, 16'hFFFF, -1, -1, 32'hA0, 0, 4);
    check("basic_rlast_now", rlast, 1);
    check("basic_ready_on_rlast", bus_ready, 1);
    @(negedge clk);
    check("basic_npulses", pq.size(), 4);
    if (pq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("basic_data", pq[i].d, 32'hA0 + i);
        check("basic_last", pq[i].l, i == 3);
        check("basic_consec", pq[i].c - pq[0].c, i);
      end
    check("basic_araddr", ar_seen, 32'h8000_0010);
    check("basic_ar_cycles", arv_cnt - a0, 1);
    // AR stall
    a0 = arv_cnt; pq.delete();
    do_fill(32'h0000_1238, 5, 16'hFFFF, -1, -1, 32'hB0, 0, 4);
    @(negedge clk);
    check("stall_ar_cycles", arv_cnt - a0, 6);
    check("stall_araddr", ar_seen, 32'h0000_1230);
    check("stall_npulses", pq.size(), 4);
    // R gaps 1,0,0,1,1,0,1
    pq.delete();
    do_fill(32'h0000_0040, 0, 16'h0059, -1, -1, 32'hD0, 0, 4);
    @(negedge clk);
    check("gap_npulses", pq.size(), 4);
    if (pq.size() == 4) begin
      check("gap_off1", pq[1].c - pq[0].c, 3);
      check("gap_off2", pq[2].c - pq[0].c, 4);
      check("gap_off3", pq[3].c - pq[0].c, 6);
      check("gap_last3", pq[3].l, 1);
      check("gap_last2", pq[2].l, 0);
    end
    // error beats
    pq.delete();
    do_fill(32'h0000_0080, 0, 16'hFFFF, 1, -1, 32'hE0, 0, 4);
    do_fill(32'h0000_00C0, 0, 16'hFFFF, -1, 2, 32'hF0, 0, 4);
    @(negedge clk);
    check("err_npulses", pq.size(), 8);
    if (pq.size() == 8)
      for (int i = 0; i < 8; i++) begin
        check("err_flag", pq[i].e, i == 1 || i == 6);
        check("err_data", pq[i].d, (i < 4) ? 32'hE0 + i : 32'hF0 + i - 4);
      end
    check("err_idle", bus_ready, 1);
    // back-to-back
    pq.delete(); arq.delete();
    do_fill(32'h0000_0100, 0, 16'hFFFF, -1, -1, 32'h10, 1, 4);
    do_fill(32'h0000_0204, 0, 16'hFFFF, -1, -1, 32'h20, 0, 4);
    @(negedge clk);
    check("b2b_npulses", pq.size(), 8);
    check("b2b_nar", arq.size(), 2);
    if (pq.size() == 8 && arq.size() == 2) check("b2b_ar_after_rlast", arq[1], pq[3].c + 1);
    check("b2b_addr2", ar_seen, 32'h0000_0200);
    // mid-burst reset
    do_fill(32'h0000_0300, 0, 16'hFFFF, -1, -1, 32'h30, 0, 2);
    #2 rst_n = 0;
    #1;
    check("mrst_bus_ready", bus_ready, 1);
    check("mrst_rvalid", rvalid, 0);
    check("mrst_rlast", rlast, 0);
    check("mrst_rdata", rdata, 0);
    check("mrst_m_arvalid", m_arvalid, 0);
    check("mrst_m_rready", m_rready, 0);
    check("mrst_m_araddr", m_araddr, 0);
    @(negedge clk); rst_n = 1;
    pq.delete();
    do_fill(32'h0000_0404, 0, 16'hFFFF, -1, -1, 32'hC0, 0, 4);
    @(negedge clk);
    check("post_npulses", pq.size(), 4);
    if (pq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("post_last", pq[i].l, i == 3);
        check("post_err", pq[i].e, 0);
        check("post_data", pq[i].d, 32'hC0 + i);
      end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_l1i_bus_bridge.md
# ysyx_l1i_bus_bridge

Refill responder for the instruction cache. Sits on the slave side of `l1i_bus_if`, accepts one line-fill request from the L1I, issues a single AXI4 INCR burst read to memory, and returns the line to the L1I one word per beat with `rlast` on the final word. Responses are in order, with one request in flight at a time. The L1I cannot apply backpressure.

## Interface
- `XLEN`, 32, word width in bits; also the AXI data width.
- `LINE_WORDS`, 4, words per L1I line; a power of 2, range 2..256.
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-low.
- `arvalid` in 1: L1I line-fill request.
- `araddr` in XLEN: fill address; any byte address inside the line.
- `bus_ready` out 1: bridge idle; a request is accepted when `arvalid && bus_ready`.
- `rdata` out XLEN: returned instruction word.
- `rvalid` out 1: `rdata` valid this cycle; a one-cycle pulse per beat.
- `rlast` out 1: this beat is the last word of the line.
- `m_arvalid` out 1, `m_arready` in 1: AXI AR handshake.
- `m_araddr` out XLEN: line-aligned burst address.
- `m_arlen` out 8, `m_arsize` out 3, `m_arburst` out 2: burst descriptor.
- `m_rvalid` in 1, `m_rready` out 1, `m_rdata` in XLEN, `m_rresp` in 2, `m_rlast` in 1: AXI R channel.
- `bus_err` out 1: one-cycle pulse on a response or protocol error.

## Operation
- States:
  - IDLE: `bus_ready`=1. On `arvalid`, latch the aligned address and go to AR.
  - AR: `m_arvalid`=1. On `m_arready`, go to R.
  - R: `m_rready`=1. Count beats; after the final beat, go to IDLE.
- Alignment: `m_araddr = araddr & ~(LINE_WORDS*XLEN/8 - 1)`.
- Burst descriptor:
  - `m_arlen = LINE_WORDS-1`.
  - `m_arsize = log2(XLEN/8)`, which is 2 for XLEN=32.
  - `m_arburst = 2'b01` (INCR).
- `m_araddr`, `m_arlen`, `m_arsize` and `m_arburst` are stable while `m_arvalid`=1.
- Beat counter: log2(LINE_WORDS) bits, cleared on entering R, incremented on each `m_rvalid && m_rready`. The final beat is `cnt == LINE_WORDS-1`.
- `rlast` is derived from the counter, not from `m_rlast`.
- Errors: any of the following causes a `bus_err` pulse on the cycle that `rvalid` is presented for that beat. Data is still forwarded and the burst still completes.
  - `m_rresp != 0` on any beat.
  - `m_rlast` disagreeing with the counter's final-beat condition.
- `m_rvalid` outside R is ignored; no output is produced.
- `arvalid` while `bus_ready`=0 is not accepted. The L1I holds the request until it is accepted.
- Reset asserted at any time:
  - The FSM returns to IDLE immediately.
  - The counter clears.
  - Any in-flight burst is abandoned; reset is global, so memory resets too.
- Reset values:
  - `bus_ready`=1.
  - `rvalid`=0, `rlast`=0, `rdata`=0.
  - `m_arvalid`=0, `m_araddr`=0, `m_rready`=0, `bus_err`=0.
  - `m_arlen`, `m_arsize` and `m_arburst` are constants.

## Timing
- Request accept at cycle T: `bus_ready`=0 and `m_arvalid`=1 from T+1.
- AR handshake at cycle A (`m_arready`=1): `m_arvalid`=0 and `m_rready`=1 from A+1.
- Beat handshake at cycle t: `rvalid`=1 with `rdata = m_rdata` at t+1. All L1I-side outputs are registered.
- Final beat handshake at cycle f:
  - `rvalid`=1, `rlast`=1 at f+1.
  - State is IDLE at f+1, so `bus_ready`=1 at f+1.
  - A new request can be accepted at f+1, giving `m_arvalid` at f+2.
- Minimum fill latency with zero-wait memory: accept T, AR at T+1, beats at T+2..T+1+LINE_WORDS, last word delivered at T+2+LINE_WORDS.
- Gaps in `m_rvalid` produce matching gaps in `rvalid`; the counter holds across gaps.

## Test plan
- Basic fill:
  - Stimulus: `araddr`=0x8000_0014, LINE_WORDS=4, memory with `m_arready`=1 immediately and back-to-back beats 0xA0..0xA3.
  - Required: `m_araddr`=0x8000_0010, `m_arlen`=3, `m_arsize`=2, `m_arburst`=1; `rvalid` on 4 consecutive cycles with `rdata` 0xA0..0xA3 and `rlast` only on 0xA3; `bus_ready` returns on the `rlast` cycle.
- AR stall:
  - Stimulus: `m_arready` low for 5 cycles.
  - Required: `m_arvalid` and `m_araddr` constant throughout; `m_rready`=0 until the cycle after the handshake.
- R gaps:
  - Stimulus: `m_rvalid` pattern 1,0,0,1,1,0,1.
  - Required: `rvalid` follows the same pattern delayed by 1; `rlast` on the 4th pulse.
- Error beat:
  - Stimulus: `m_rresp`=2 on beat 1; separately, `m_rlast`=1 on beat 2.
  - Required: `bus_err` pulses coincide with the corresponding `rvalid` beats; all 4 words still delivered; FSM back in IDLE.
- Back-to-back requests:
  - Stimulus: `arvalid` held high across two fills.
  - Required: second fill accepted on the first fill's `rlast` cycle; second `m_arvalid` one cycle later.
- Mid-burst reset:
  - Stimulus: `reset` low after beat 2.
  - Required: outputs immediately take their reset values, including `bus_ready`=1 and `rvalid`=0; after release, a new fill completes with the counter starting at 0.
